cdc_hs_src: RTL and testbench
=============================

CDC_HS_SRC -- requirements
Module: cdc_hs_src

Interface
REQ-001 Parameter WIDTH, default 8, width of the transferred data word.
REQ-002 Parameter DEPTH, default 2, number of flops in the internal ack synchronizer; DEPTH < 2 SHALL cause an elaboration error.
REQ-003 clk  input  1  source-domain clock; all state changes on its rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 valid_i  input  1  source-side request to send data_i.
REQ-006 data_i  input  WIDTH  word to transfer, sampled only on accept.
REQ-007 ready_o  output  1  block can accept a word this cycle.
REQ-008 req_o  output  1  registered 4-phase request toward the destination domain.
REQ-009 data_o  output  WIDTH  registered data bus toward the destination domain, stable while req_o is high.
REQ-010 ack_i  input  1  4-phase acknowledge from the destination domain, asynchronous to clk.
REQ-011 done_o  output  1  one-cycle pulse when a transfer fully completes.
REQ-012 err_o  output  1  sticky protocol-error flag.

Function
REQ-013 ack_i SHALL enter a DEPTH-flop shift chain with no logic before the first flop; ack_s is the last stage; only ack_s is used internally.
REQ-014 The FSM SHALL have states IDLE, WAIT_HI, WAIT_LO.
REQ-015 ready_o SHALL be combinational: 1 iff state == IDLE and ack_s == 0.
REQ-016 Accept: valid_i && ready_o at edge N -> data_o <= data_i, req_o <= 1, state <= WAIT_HI, all at edge N.
REQ-017 valid_i and data_i SHALL be ignored whenever ready_o == 0.
REQ-018 WAIT_HI: req_o held 1, data_o held; on the edge where ack_s == 1, req_o <= 0, state <= WAIT_LO.
REQ-019 WAIT_LO: req_o held 0, data_o held; on the edge where ack_s == 0, state <= IDLE and done_o <= 1 for exactly one cycle.
REQ-020 data_o SHALL change only on accept edges; req_o and data_o change on the same edge, destination relies on req synchronization for data settling.
REQ-021 Latency: ack_i rise settling before edge M SHALL make ack_s high after edge M+DEPTH-1 and req_o fall at edge M+DEPTH.
REQ-022 Minimum transfer period with an immediate responder is not fixed by this block; back-to-back accepts SHALL be possible the cycle after done_o asserts, provided ack_s == 0.
REQ-023 err_o SHALL be set (registered) on any edge where state == IDLE and ack_s == 1, and cleared only by reset; ready_o stays low while ack_s == 1 in IDLE.
REQ-024 ack_s falling in WAIT_HI or rising in WAIT_LO is not possible without an ack_s edge in the expected direction first; no other transitions exist.

Reset
REQ-025 rstn low SHALL asynchronously force state IDLE, req_o 0, data_o 0, done_o 0, err_o 0, sync chain all 0; ready_o therefore 1 during/after reset while ack_s == 0.
REQ-026 Reset mid-transfer SHALL abort the transfer without done_o; if the destination still drives ack_i high, ack_s rises DEPTH edges after rstn release and err_o sets.
REQ-027 After rstn deassertion, first accept SHALL be possible at the first clk edge.

Verification
REQ-028 DEPTH=2, WIDTH=8: valid_i=1, data_i=0xA5 at edge 0 -> req_o=1, data_o=0xA5 after edge 0; ready_o=0 until done_o.
REQ-029 Responder raises ack_i 3 cycles after req_o, drops it 3 cycles after req_o falls -> req_o falls 2 edges after ack_i rise, done_o one-cycle pulse 2 edges after ack_i fall, data_o stays 0xA5 throughout.
REQ-030 Change data_i to 0x3C and toggle valid_i during WAIT_HI/WAIT_LO -> data_o remains 0xA5, no second req_o.
REQ-031 Force ack_i=1 while IDLE and req_o=0 -> err_o=1 after DEPTH+1 edges, ready_o=0, err_o stays 1 after ack_i returns 0 until rstn.
REQ-032 Assert rstn=0 during WAIT_HI -> req_o, data_o, done_o immediately 0; no done_o pulse; with ack_i=0, ready_o=1 and new accept at first edge after release.
REQ-033 DEPTH=3, 100 random-gap transfers with random data -> every accepted word appears on data_o with exactly one req_o high phase and one done_o pulse, in order.

Source files
------------

// File: rtl/cdc_hs_src_if.sv
// rtl/cdc_hs_src_if.sv - handshake bundle between the source logic and the 4-phase CDC sender
interface cdc_hs_src_if #(
  parameter int WIDTH = 8
);
  logic             valid_i;
  logic [WIDTH-1:0] data_i;
  logic             ready_o;
  logic             req_o;
  logic [WIDTH-1:0] data_o;
  logic             ack_i;
  logic             done_o;
  logic             err_o;

  modport master (
    input  valid_i, data_i, ack_i,
    output ready_o, req_o, data_o, done_o, err_o
  );

  modport slave (
    output valid_i, data_i, ack_i,
    input  ready_o, req_o, data_o, done_o, err_o
  );
endinterface

// File: rtl/cdc_hs_src.sv
// rtl/cdc_hs_src.sv - source side of a 4-phase req/ack clock-domain-crossing handshake
module cdc_hs_src #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  cdc_hs_src_if.master hs
);

  generate
    if (DEPTH < 2) begin : g_depth_chk
      $error("cdc_hs_src: DEPTH must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] sync_q;
  logic             ack_s;
  logic             ready;
  logic             req_q, req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // ack_i is asynchronous: it lands directly in the first flop, nothing else reads it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], hs.ack_i};
    end
  end

  assign ack_s = sync_q[DEPTH-1];
  assign ready = (state_q == IDLE) && !ack_s;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // ack still high while idle means the destination is out of step
        if (ack_s) begin
          err_d = 1'b1;
        end else if (hs.valid_i) begin
          data_d  = hs.data_i;
          req_d   = 1'b1;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign hs.ready_o = ready;
  assign hs.req_o   = req_q;
  assign hs.data_o  = data_q;
  assign hs.done_o  = done_q;
  assign hs.err_o   = err_q;

endmodule

// File: tb/tb_cdc_hs_src.sv
// tb/tb_cdc_hs_src.sv - directed and randomized-gap checks of the 4-phase CDC source
module tb_cdc_hs_src;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cdc_hs_src_if #(.WIDTH(8)) h2 ();
  cdc_hs_src_if #(.WIDTH(8)) h3 ();

  cdc_hs_src #(.WIDTH(8), .DEPTH(2)) u_dut2 (.clk(clk), .rstn(rstn), .hs(h2.master));
  cdc_hs_src #(.WIDTH(8), .DEPTH(3)) u_dut3 (.clk(clk), .rstn(rstn), .hs(h3.master));

  int   req_rises  = 0;
  int   done_cnt   = 0;
  int   done_multi = 0;
  logic prev_req3  = 1'b0;
  logic prev_done3 = 1'b0;

  // counts request phases and done pulses seen on the DEPTH=3 instance
  always @(negedge clk) begin
    if (h3.req_o === 1'b1 && prev_req3 !== 1'b1) req_rises++;
    if (h3.done_o === 1'b1) done_cnt++;
    if (h3.done_o === 1'b1 && prev_done3 === 1'b1) done_multi++;
    prev_req3  <= h3.req_o;
    prev_done3 <= h3.done_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] d;
    int         n;

    rstn       = 1'b0;
    h2.valid_i = 1'b0;
    h2.data_i  = 8'h00;
    h2.ack_i   = 1'b0;
    h3.valid_i = 1'b0;
    h3.data_i  = 8'h00;
    h3.ack_i   = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(h2.ready_o), 32'd1);
    chk("rst_req",   32'(h2.req_o),   32'd0);
    chk("rst_data",  32'(h2.data_o),  32'h00);
    chk("rst_done",  32'(h2.done_o),  32'd0);
    chk("rst_err",   32'(h2.err_o),   32'd0);

    // first accept at the first edge after release
    rstn       = 1'b1;
    h2.valid_i = 1'b1;
    h2.data_i  = 8'hA5;
    tick();
    chk("acc_req",   32'(h2.req_o),   32'd1);
    chk("acc_data",  32'(h2.data_o),  32'hA5);
    chk("acc_ready", 32'(h2.ready_o), 32'd0);
    h2.data_i = 8'h3C;
    tick();
    tick();
    tick();
    chk("whi_req",  32'(h2.req_o),  32'd1);
    chk("whi_data", 32'(h2.data_o), 32'hA5);
    h2.ack_i = 1'b1;
    tick();
    chk("ackr1_req", 32'(h2.req_o), 32'd1);
    tick();
    chk("ackr2_req",   32'(h2.req_o),   32'd1);
    chk("ackr2_ready", 32'(h2.ready_o), 32'd0);
    h2.valid_i = 1'b0;
    tick();
    chk("reqfall_req",  32'(h2.req_o),  32'd0);
    chk("reqfall_data", 32'(h2.data_o), 32'hA5);
    h2.valid_i = 1'b1;
    tick();
    tick();
    tick();
    chk("wlo_req",  32'(h2.req_o),  32'd0);
    chk("wlo_done", 32'(h2.done_o), 32'd0);
    chk("wlo_data", 32'(h2.data_o), 32'hA5);
    h2.ack_i = 1'b0;
    tick();
    chk("ackf1_done", 32'(h2.done_o), 32'd0);
    tick();
    chk("ackf2_done",  32'(h2.done_o),  32'd0);
    chk("ackf2_ready", 32'(h2.ready_o), 32'd0);
    tick();
    chk("done_pulse", 32'(h2.done_o),  32'd1);
    chk("done_ready", 32'(h2.ready_o), 32'd1);
    chk("done_data",  32'(h2.data_o),  32'hA5);
    chk("done_req",   32'(h2.req_o),   32'd0);

    // back-to-back accept the cycle after done
    tick();
    chk("b2b_done", 32'(h2.done_o), 32'd0);
    chk("b2b_req",  32'(h2.req_o),  32'd1);
    chk("b2b_data", 32'(h2.data_o), 32'h3C);
    h2.valid_i = 1'b0;
    h2.ack_i   = 1'b1;
    tick();
    tick();
    chk("b2b_req_hold", 32'(h2.req_o), 32'd1);
    tick();
    chk("b2b_req_fall", 32'(h2.req_o), 32'd0);
    h2.ack_i = 1'b0;
    tick();
    tick();
    chk("b2b_done_early", 32'(h2.done_o), 32'd0);
    tick();
    chk("b2b_done", 32'(h2.done_o), 32'd1);
    tick();
    chk("b2b_done_end", 32'(h2.done_o), 32'd0);

    // reset in WAIT_HI aborts without done
    h2.valid_i = 1'b1;
    h2.data_i  = 8'h5A;
    tick();
    chk("mid_req",  32'(h2.req_o),  32'd1);
    chk("mid_data", 32'(h2.data_o), 32'h5A);
    h2.valid_i = 1'b0;
    rstn = 1'b0;
    #1;
    chk("arst_req",   32'(h2.req_o),   32'd0);
    chk("arst_data",  32'(h2.data_o),  32'h00);
    chk("arst_done",  32'(h2.done_o),  32'd0);
    chk("arst_ready", 32'(h2.ready_o), 32'd1);
    tick();
    rstn       = 1'b1;
    h2.valid_i = 1'b1;
    h2.data_i  = 8'h77;
    tick();
    chk("rel_req",  32'(h2.req_o),  32'd1);
    chk("rel_data", 32'(h2.data_o), 32'h77);
    chk("rel_done", 32'(h2.done_o), 32'd0);
    h2.valid_i = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;

    // spurious ack in IDLE sets the sticky error
    h2.ack_i = 1'b1;
    tick();
    tick();
    chk("err_early", 32'(h2.err_o),   32'd0);
    chk("err_ready", 32'(h2.ready_o), 32'd0);
    tick();
    chk("err_set", 32'(h2.err_o), 32'd1);
    chk("err_req", 32'(h2.req_o), 32'd0);
    h2.ack_i = 1'b0;
    tick();
    tick();
    chk("err_sticky",   32'(h2.err_o),   32'd1);
    chk("err_ready_bk", 32'(h2.ready_o), 32'd1);
    rstn = 1'b0;
    #1;
    chk("err_clr", 32'(h2.err_o), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // DEPTH=3 instance: random gaps, random data, in-order delivery
    for (int i = 0; i < 100; i++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      h3.valid_i = 1'b1;
      h3.data_i  = d;
      tick();
      h3.valid_i = 1'b0;
      h3.data_i  = ~d;
      chk("r_acc",  32'(h3.req_o),  32'd1);
      chk("r_data", 32'(h3.data_o), 32'(d));
      repeat ($urandom_range(0, 3)) tick();
      h3.ack_i = 1'b1;
      n = 0;
      while (h3.req_o === 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("r_reqfall", 32'(h3.req_o),  32'd0);
      chk("r_hold",    32'(h3.data_o), 32'(d));
      repeat ($urandom_range(0, 3)) tick();
      h3.ack_i = 1'b0;
      n = 0;
      while (h3.done_o !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("r_done", 32'(h3.done_o), 32'd1);
    end
    tick();
    tick();
    chk("r_req_phases", 32'(req_rises),  32'd100);
    chk("r_done_count", 32'(done_cnt),   32'd100);
    chk("r_done_width", 32'(done_multi), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
